wb_uart_tx: RTL and testbench

Wishbone responder exposing a memory-mapped transmit-only UART console to the hart. It sits on the hart's data bus next to `block_ram` and uses the same single-cycle-ack bus discipline. Bytes written by software are queued in a small FIFO and serialised as 8N1 frames on `o_tx`. A status register gives software the FIFO and line state for polling.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/sync_fifo.sv | 73 +++++++
 rtl/wb_uart_tx.sv | 209 ++++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the Wishbone transmit-only UART console.
package uart_pkg;

    // Transmit FSM states
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

    // Register indices decoded from the word address bits [3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;

    // STATUS register field positions
    localparam int STAT_FULL_BIT  = 0;
    localparam int STAT_EMPTY_BIT = 1;
    localparam int STAT_BUSY_BIT  = 2;
    localparam int STAT_OVF_BIT   = 3;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 8;

    // Assemble the low 16 bits of STATUS; the caller zero-extends to bus width
    function automatic logic [15:0] pack_status(
        input logic       full,
        input logic       empty,
        input logic       busy,
        input logic       ovf,
        input logic [7:0] count
    );
        logic [15:0] s;
        s = 16'h0000;
        s[STAT_FULL_BIT]  = full;
        s[STAT_EMPTY_BIT] = empty;
        s[STAT_BUSY_BIT]  = busy;
        s[STAT_OVF_BIT]   = ovf;
        s[STAT_COUNT_LSB +: STAT_COUNT_W] = count;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with natural-wrap pointers and an occupancy counter.
// Pushes while full and pops while empty are ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_pop_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic             rd_en_s;

    // Occupancy flags and qualified push/pop enables
    always_comb begin
        full_s  = (count_r == COUNT_FULL);
        empty_s = (count_r == '0);
        wr_en_s = i_push && !full_s;
        rd_en_s = i_pop && !empty_s;
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge i_clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= i_push_data;
        end
    end

    assign o_pop_data = mem_r[rd_ptr_r];
    assign o_full     = full_s;
    assign o_empty    = empty_s;
    assign o_count    = count_r;

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone responder for a transmit-only 8N1 UART console: TXDATA pushes
// into a small FIFO, STATUS reports FIFO/line state, and a four-state FSM
// serialises queued bytes on o_tx with no gap between consecutive frames.
module wb_uart_tx
    import uart_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_wb_stb,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_wb_we,
    input  logic [2:0]      i_wb_sel,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_wb_stall,
    output logic            o_wb_ack,
    output logic            o_tx
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    // Bus side
    logic [1:0]      reg_idx_s;
    logic            wr_txdata_s;
    logic            rd_status_s;
    logic            overflow_set_s;
    logic [XLEN-1:0] status_s;
    logic [XLEN-1:0] rd_data_s;
    logic            overflow_r;
    logic            ack_r;
    logic [XLEN-1:0] rd_data_r;

    // FIFO side
    logic [7:0]       fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             pop_s;

    // Transmitter
    tx_state_e         state_r;
    tx_state_e         state_nxt_s;
    logic [BAUD_W-1:0] baud_r;
    logic [BAUD_W-1:0] baud_nxt_s;
    logic [2:0]        bit_idx_r;
    logic [2:0]        bit_idx_nxt_s;
    logic [7:0]        shift_r;
    logic [7:0]        shift_nxt_s;
    logic              tx_r;
    logic              tx_nxt_s;
    logic              baud_last_s;

    // Only the word index and low data byte are meaningful on this port
    logic unused_s;
    assign unused_s = ^{i_wb_sel, i_addr[XLEN-1:4], i_addr[1:0], i_data[XLEN-1:8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_push      (wr_txdata_s),
        .i_push_data (i_data[7:0]),
        .i_pop       (pop_s),
        .o_pop_data  (fifo_head_s),
        .o_full      (fifo_full_s),
        .o_empty     (fifo_empty_s),
        .o_count     (fifo_count_s)
    );

    // Register decode, STATUS assembly and read-data mux
    always_comb begin
        reg_idx_s      = i_addr[3:2];
        wr_txdata_s    = i_wb_stb && i_wb_we && (reg_idx_s == REG_TXDATA);
        rd_status_s    = i_wb_stb && !i_wb_we && (reg_idx_s == REG_STATUS);
        // Full is judged on the pre-pop count, so a push racing a pop while full is dropped
        overflow_set_s = wr_txdata_s && fifo_full_s;
        status_s       = XLEN'(pack_status(fifo_full_s, fifo_empty_s,
                                           (state_r != TX_IDLE), overflow_r,
                                           8'(fifo_count_s)));
        rd_data_s      = {XLEN{1'b0}};
        if (rd_status_s) begin
            rd_data_s = status_s;
        end else begin
            rd_data_s = {XLEN{1'b0}};
        end
    end

    // Single-cycle acknowledge, registered read data and sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ack_r      <= 1'b0;
            rd_data_r  <= {XLEN{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            ack_r     <= i_wb_stb;
            rd_data_r <= rd_data_s;
            // A fresh overflow wins over a same-cycle STATUS read clear
            if (overflow_set_s) begin
                overflow_r <= 1'b1;
            end else if (rd_status_s) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    // Transmit FSM next-state, FIFO pop and next line level
    always_comb begin
        state_nxt_s   = state_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        pop_s         = 1'b0;
        baud_last_s   = (baud_r == BAUD_LAST);
        // Free-running wrap doubles as the clear on every state entry from START/DATA/STOP
        if (baud_last_s) begin
            baud_nxt_s = {BAUD_W{1'b0}};
        end else begin
            baud_nxt_s = baud_r + 1'b1;
        end

        case (state_r)
            TX_IDLE: begin
                baud_nxt_s = {BAUD_W{1'b0}};
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_head_s;
                    state_nxt_s = TX_START;
                end else begin
                    state_nxt_s = TX_IDLE;
                end
            end
            TX_START: begin
                if (baud_last_s) begin
                    state_nxt_s   = TX_DATA;
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = TX_START;
                end
            end
            TX_DATA: begin
                if (baud_last_s) begin
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = TX_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_nxt_s = TX_DATA;
                end
            end
            TX_STOP: begin
                if (baud_last_s) begin
                    if (!fifo_empty_s) begin
                        pop_s       = 1'b1;
                        shift_nxt_s = fifo_head_s;
                        state_nxt_s = TX_START;
                    end else begin
                        state_nxt_s = TX_IDLE;
                    end
                end else begin
                    state_nxt_s = TX_STOP;
                end
            end
            default: begin
                state_nxt_s = TX_IDLE;
                baud_nxt_s  = {BAUD_W{1'b0}};
            end
        endcase

        // Line level follows the state being entered so o_tx lines up with state_r
        case (state_nxt_s)
            TX_START: tx_nxt_s = 1'b0;
            TX_DATA:  tx_nxt_s = shift_nxt_s[bit_idx_nxt_s];
            default:  tx_nxt_s = 1'b1;
        endcase
    end

    // Transmit FSM state, baud counter, bit index, shift register and line register
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_r   <= TX_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            tx_r      <= tx_nxt_s;
        end
    end

    assign o_wb_ack   = ack_r;
    assign o_wb_data  = rd_data_r;
    assign o_wb_stall = 1'b0;
    assign o_tx       = tx_r;

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx with CLK_DIV=4, FIFO_DEPTH=8. Read data and
// transmitted bytes are checked against scoreboard queues filled at stimulus time.
module tb_wb_uart_tx;

    localparam int XLEN = 32;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_wb_stb = 1'b0;
    logic [XLEN-1:0] i_addr = '0;
    logic [XLEN-1:0] i_data = '0;
    logic            i_wb_we = 1'b0;
    logic [2:0]      i_wb_sel = 3'd0;
    logic [XLEN-1:0] o_wb_data;
    logic            o_wb_stall;
    logic            o_wb_ack;
    logic            o_tx;

    wb_uart_tx #(.XLEN(XLEN), .CLK_DIV(4), .FIFO_DEPTH(8)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wb_stb   (i_wb_stb),
        .i_addr     (i_addr),
        .i_data     (i_data),
        .i_wb_we    (i_wb_we),
        .i_wb_sel   (i_wb_sel),
        .o_wb_data  (o_wb_data),
        .o_wb_stall (o_wb_stall),
        .o_wb_ack   (o_wb_ack),
        .o_tx       (o_tx)
    );

    always #5 i_clk = ~i_clk;

    // Cycle counter: value k during the cycle that follows posedge number k
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Line receiver: decodes 8N1 frames (4 cycles/bit) sampled mid-bit on negedges
    logic [7:0] rx_byte [0:31];
    bit         rx_stop [0:31];
    int         rx_start[0:31];
    int         rx_n = 0;
    bit         rx_busy = 1'b0;
    int         rx_t0 = 0;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge i_clk) begin
        if (i_reset !== 1'b1) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (o_tx === 1'b0) begin
                rx_busy <= 1'b1;
                rx_t0   <= cyc;
            end
        end else begin
            if ((cyc - rx_t0) >= 6 && (cyc - rx_t0) <= 34 && ((cyc - rx_t0 - 6) % 4) == 0)
                rx_sh[(cyc - rx_t0 - 6) / 4] <= o_tx;
            if ((cyc - rx_t0) == 38) begin
                if (rx_n < 32) begin
                    rx_byte[rx_n]  <= rx_sh;
                    rx_stop[rx_n]  <= (o_tx === 1'b1);
                    rx_start[rx_n] <= rx_t0;
                    rx_n           <= rx_n + 1;
                end
                rx_busy <= 1'b0;
            end
        end
    end

    int checks = 0;
    int failures = 0;
    logic [31:0] rd_q[$];
    logic [7:0]  exp_q[$];
    bit          prev_stb = 1'b0;
    bit          prev_rd = 1'b0;
    int          rx_rd = 0;

    function automatic void check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endfunction

    // One bus cycle: check ack/read data of the previous cycle, then drive this one
    task automatic step(input bit stb, input bit we, input logic [1:0] rg,
                        input logic [31:0] dat, input logic [2:0] sel, input bit rst_n);
        logic [31:0] e;
        @(posedge i_clk);
        #1;
        check("ack", {31'd0, o_wb_ack}, {31'd0, prev_stb});
        if (prev_stb && prev_rd) begin
            if (rd_q.size() == 0) begin
                check("rd_q_empty", 32'd1, 32'd0);
            end else begin
                e = rd_q.pop_front();
                check("rdata", o_wb_data, e);
            end
        end
        i_reset  = rst_n;
        i_wb_stb = stb;
        i_wb_we  = we;
        i_addr   = 32'h1000_0000 | {28'd0, rg, 2'b00};
        i_data   = dat;
        i_wb_sel = sel;
        prev_stb = stb && rst_n;
        prev_rd  = stb && !we && rst_n;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b1);
    endtask

    task automatic wr(input logic [31:0] dat, input logic [2:0] sel);
        step(1'b1, 1'b1, 2'd0, dat, sel, 1'b1);
    endtask

    task automatic rd(input logic [1:0] rg, input logic [31:0] exp);
        step(1'b1, 1'b0, rg, 32'hFFFF_FFFF, 3'd2, 1'b1);
        rd_q.push_back(exp);
    endtask

    task automatic idle_to(input int k);
        while (cyc < k) idle();
    endtask

    // Compare the next n received frames against the expected-byte queue
    task automatic check_frames(input int n);
        logic [7:0] e;
        check("frame_count", 32'(rx_n - rx_rd), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0 || rx_rd >= rx_n) begin
                check("frame_missing", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("frame_byte", {24'd0, rx_byte[rx_rd]}, {24'd0, e});
                check("frame_stop", {31'd0, rx_stop[rx_rd]}, 32'd1);
                rx_rd++;
            end
        end
    endtask

    int c0, d, e, f, base_rx;

    initial begin
        // Reset with a strobe held: no ack, line high, data zero
        step(1'b1, 1'b0, 2'd1, 32'd0, 3'd0, 1'b0);
        step(1'b1, 1'b0, 2'd1, 32'd0, 3'd0, 1'b0);
        idle();
        check("rst_tx", {31'd0, o_tx}, 32'd1);
        check("rst_data", o_wb_data, 32'd0);
        check("stall", {31'd0, o_wb_stall}, 32'd0);

        // 1: STATUS after reset
        rd(2'd1, 32'h0000_0002);
        idle();
        check("t1_tx", {31'd0, o_tx}, 32'd1);
        idle();

        // 2: single 0x55 frame with exact bit timing
        wr(32'h0000_0055, 3'd0);
        c0 = cyc;
        exp_q.push_back(8'h55);
        idle_to(c0 + 1);
        check("t2_tx_c1", {31'd0, o_tx}, 32'd1);
        idle_to(c0 + 2);
        check("t2_start_c2", {31'd0, o_tx}, 32'd0);
        rd(2'd1, 32'h0000_0006);
        idle_to(c0 + 5);
        check("t2_start_c5", {31'd0, o_tx}, 32'd0);
        idle_to(c0 + 6);
        check("t2_bit0", {31'd0, o_tx}, 32'd1);
        idle_to(c0 + 10);
        check("t2_bit1", {31'd0, o_tx}, 32'd0);
        idle_to(c0 + 37);
        check("t2_bit7", {31'd0, o_tx}, 32'd0);
        idle_to(c0 + 38);
        check("t2_stop_c38", {31'd0, o_tx}, 32'd1);
        idle_to(c0 + 44);
        rd(2'd1, 32'h0000_0002);
        idle();
        check("t2_start_cycle", 32'(rx_start[rx_rd]), 32'(c0 + 2));
        check_frames(1);

        // 3: upper data bits and size code ignored; back-to-back frames; TXDATA reads 0
        wr(32'hDEAD_BEA5, 3'd0);
        d = cyc;
        exp_q.push_back(8'hA5);
        wr(32'hDEAD_BEA5, 3'd2);
        exp_q.push_back(8'hA5);
        rd(2'd0, 32'h0000_0000);
        rd(2'd2, 32'h0000_0000);
        idle_to(d + 90);
        check("t3_first_start", 32'(rx_start[rx_rd]), 32'(d + 2));
        check("t3_gap", 32'(rx_start[rx_rd + 1] - rx_start[rx_rd]), 32'd40);
        check_frames(2);

        // 4 and 6: overflow, sticky clear, pop/push race while full
        base_rx = rx_rd;
        wr(32'h0000_0010, 3'd0);
        e = cyc;
        for (int i = 1; i < 10; i++) wr(32'h0000_0010 + 32'(i), 3'd0);
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
        rd(2'd1, 32'h0000_080D);
        rd(2'd1, 32'h0000_0805);
        idle_to(e + 40);
        wr(32'h0000_0077, 3'd0);
        rd(2'd1, 32'h0000_070C);
        rd(2'd1, 32'h0000_0704);
        idle_to(e + 372);
        check("t4_first_start", 32'(rx_start[base_rx]), 32'(e + 2));
        check("t4_span", 32'(rx_start[base_rx + 8] - rx_start[base_rx]), 32'd320);
        check_frames(9);
        check("t4_idle_tx", {31'd0, o_tx}, 32'd1);

        // 5: reset in the middle of data bit 1 with bytes queued
        wr(32'h0000_00A1, 3'd0);
        f = cyc;
        wr(32'h0000_00A2, 3'd0);
        wr(32'h0000_00A3, 3'd0);
        idle_to(f + 10);
        step(1'b0, 1'b0, 2'd0, 32'd0, 3'd0, 1'b0);
        check("t5_tx_low_before", {31'd0, o_tx}, 32'd0);
        idle();
        check("t5_tx_high_after", {31'd0, o_tx}, 32'd1);
        rd(2'd1, 32'h0000_0002);
        idle_to(f + 120);
        check("t5_tx_idle", {31'd0, o_tx}, 32'd1);
        check_frames(0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
